bus_load_bank: RTL and testbench
================================

# bus_load_bank

Receiving end of the 32-bit datapath bus: the block that loads the 24 bus-source registers the bus multiplexer selects from. It takes a bus value plus a 5-bit destination code, holds them for one pipeline stage, and writes the addressed register one cycle later. All 24 registers are exported as one flat vector using the same code map as the multiplexer select: R0–R15, HI, LO, ZHI, ZLO, PC, MDR, InPort and C_sign_extended. It also owns the InPort capture, the 64-bit Z load from the ALU, PC increment and a sticky bad-destination flag.

## Interface
- WIDTH, 32, datapath word width; only 32 is supported.
- NREGS, 24, number of bus-source registers. Codes 0–23 are valid and 24–31 are invalid.
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous, active-low reset. It is sampled on the rising edge of clk.
- bus_data  in  32  value currently on the bus.
- dest_sel  in  5  destination code, using the multiplexer map: 0–15 Rn, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C.
- load_valid  in  1  request to load bus_data into dest_sel.
- load_ready  out  1  block can accept a load this cycle.
- z_load  in  1  load the 64-bit ALU result into ZHI:ZLO.
- alu_result  in  64  ALU output; [63:32] goes to ZHI and [31:0] to LO-side ZLO.
- pc_inc  in  1  increment PC by 1.
- inport_strobe  in  1  capture in_port into InPort.
- in_port  in  32  external input value.
- reg_bank  out  768  all registers; register i occupies [32*i+31 : 32*i].
- bad_dest  out  1  sticky flag: a load was accepted with an invalid or read-only code.
- load_count  out  8  number of committed bus loads, wrapping.

## Operation
- **Stage A (accept).** When load_valid and load_ready are both 1 at a clock edge, bus_data and dest_sel are latched into pend_data and pend_sel, and pend_v is set to 1. Otherwise pend_v is cleared to 0.
- **Stage B (commit).** When pend_v is 1, register pend_sel is written with pend_data on the next edge, and load_count increments (mod 256).
- **Codes 22 and 24–31.** A pending load with one of these codes does not write any register. It sets bad_dest and does not increment load_count. InPort is read-only from the bus.
- **Back-to-back loads.** load_ready is 1 whenever clr is 1, so one load can be accepted every cycle. Throughput is 1 load/cycle, and commits happen in acceptance order.
- **Z path.** When z_load is 1, ZHI is written with alu_result[63:32] and ZLO with alu_result[31:0] on that same edge; there is no pending stage.
- **PC path.** When pc_inc is 1, PC becomes PC+1 modulo 2^32, so 0xFFFFFFFF wraps to 0.
- **InPort path.** When inport_strobe is 1, InPort becomes in_port on that edge.
- **Priority on the same edge, per register:**
  - A committing bus load beats z_load. If the commit targets ZHI, ZLO still takes alu_result[31:0], and vice versa.
  - A committing bus load beats pc_inc.
  - inport_strobe has no conflict, because bus writes to code 22 are rejected.
- **No forwarding.** reg_bank always shows committed values only. Pending data is not visible.
- **bad_dest** stays at 1 until clr is asserted.

## Timing
- **Reset values.** When clr is 0 at an edge:
  - all 24 registers become 0; pend_v, bad_dest and load_count become 0;
  - load_ready becomes 0 combinationally while clr is 0.
- **Reset discards pending loads.** A load pending when clr is asserted is discarded and never commits.
- **Load latency.** A load accepted at edge N is visible on reg_bank after edge N+1.
- **Direct-path latency.** z_load, pc_inc and inport_strobe are visible after the edge they are sampled on.
- **Exit from reset.** The first acceptance is possible at the first edge with clr equal to 1.
- All outputs are registered except load_ready.

## Test plan
- **Reset.** Drive clr=0 for 2 cycles with load_valid=1 and dest_sel=3.
  - Required: reg_bank is all 0, load_count=0, bad_dest=0, load_ready=0.
  - Required: after release, nothing is written, because no pending load survives reset.
- **Basic loads.** Loads 20→R1, 100→R2, 145→R3, 243→R5 on consecutive cycles.
  - Required: each value appears one edge after its acceptance, at slices 1, 2, 3 and 5.
  - Required: load_count=4.
- **Invalid destinations.** Load 0xDEAD with dest_sel=22, then with dest_sel=27.
  - Required: InPort and every other register are unchanged, bad_dest=1, load_count unchanged.
  - Then capture in_port=0x55 with inport_strobe. Required: InPort=0x55.
- **Z conflict.** Set alu_result=0x00000001_00000002 with z_load on the same edge as a commit of 0x77 to code 18.
  - Required: ZHI=0x77 and ZLO=0x2.
- **PC paths.** Set PC=0xFFFFFFFF by bus load, then pc_inc.
  - Required: PC=0.
  - Then pc_inc on the same edge as a commit of 0x40 to PC. Required: PC=0x40.
- **Reset mid-operation.** Accept a load of 9→R4, then assert clr on the very next edge.
  - Required: R4=0 and load_count=0.

Source files
------------

// File: rtl/bus_load_bank_if.sv
// Bus-side load handshake into the register bank: value, destination code, valid/ready.
interface bus_load_bank_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] bus_data;
    logic [4:0]       dest_sel;
    logic             load_valid;
    logic             load_ready;

    modport master (output bus_data, output dest_sel, output load_valid, input load_ready);
    modport slave  (input bus_data, input dest_sel, input load_valid, output load_ready);
endinterface

// File: rtl/bus_load_bank.sv
// Bus-source register bank: one-stage pending bus load, direct Z/PC/InPort paths,
// sticky bad-destination flag and committed-load counter.
module bus_load_bank #(
    parameter int WIDTH = 32,
    parameter int NREGS = 24
) (
    input  logic                   clk,
    input  logic                   clr,
    bus_load_bank_if.slave         lb,
    input  logic                   z_load,
    input  logic [2*WIDTH-1:0]     alu_result,
    input  logic                   pc_inc,
    input  logic                   inport_strobe,
    input  logic [WIDTH-1:0]       in_port,
    output logic [NREGS*WIDTH-1:0] reg_bank,
    output logic                   bad_dest,
    output logic [7:0]             load_count
);
    localparam int ZHI = 18;
    localparam int ZLO = 19;
    localparam int PC  = 20;
    localparam int INP = 22;
    localparam logic [4:0] LAST_CODE = 5'(NREGS - 1);
    localparam logic [4:0] INP_CODE  = 5'(INP);

    logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
    logic [WIDTH-1:0]            pend_data_q, pend_data_d;
    logic [4:0]                  pend_sel_q, pend_sel_d;
    logic                        pend_v_q, pend_v_d;
    logic                        bad_q, bad_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic                        accept, commit_ok;

    assign lb.load_ready = clr;
    assign accept        = lb.load_valid && lb.load_ready;
    // InPort is read-only from the bus, so code 22 is rejected like out-of-range codes.
    assign commit_ok     = pend_v_q && (pend_sel_q <= LAST_CODE) && (pend_sel_q != INP_CODE);

    always_comb begin
        regs_d      = regs_q;
        pend_v_d    = accept;
        pend_data_d = accept ? lb.bus_data : pend_data_q;
        pend_sel_d  = accept ? lb.dest_sel : pend_sel_q;
        bad_d       = bad_q;
        cnt_d       = cnt_q;

        if (z_load) begin
            regs_d[ZHI] = alu_result[2*WIDTH-1:WIDTH];
            regs_d[ZLO] = alu_result[WIDTH-1:0];
        end
        if (pc_inc)
            regs_d[PC] = regs_q[PC] + WIDTH'(1);
        if (inport_strobe)
            regs_d[INP] = in_port;

        // Bus commit is applied last so it overrides the direct paths per register.
        for (int i = 0; i < NREGS; i++)
            if (commit_ok && pend_sel_q == 5'(i))
                regs_d[i] = pend_data_q;

        if (commit_ok)
            cnt_d = cnt_q + 8'd1;
        else if (pend_v_q)
            bad_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            regs_q      <= '0;
            pend_data_q <= '0;
            pend_sel_q  <= '0;
            pend_v_q    <= 1'b0;
            bad_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            regs_q      <= regs_d;
            pend_data_q <= pend_data_d;
            pend_sel_q  <= pend_sel_d;
            pend_v_q    <= pend_v_d;
            bad_q       <= bad_d;
            cnt_q       <= cnt_d;
        end
    end

    assign reg_bank   = regs_q;
    assign bad_dest   = bad_q;
    assign load_count = cnt_q;
endmodule

// File: tb/tb_bus_load_bank.sv
// Directed bench for bus_load_bank: reset, pipelined loads, rejected codes, Z/PC priority.
module tb_bus_load_bank;
    logic         clk = 1'b0;
    logic         clr;
    logic         z_load, pc_inc, inport_strobe;
    logic [63:0]  alu_result;
    logic [31:0]  in_port;
    logic [767:0] reg_bank;
    logic         bad_dest;
    logic [7:0]   load_count;

    int n_checks = 0;
    int n_errors = 0;

    bus_load_bank_if #(.WIDTH(32)) lb ();

    bus_load_bank dut (
        .clk          (clk),
        .clr          (clr),
        .lb           (lb),
        .z_load       (z_load),
        .alu_result   (alu_result),
        .pc_inc       (pc_inc),
        .inport_strobe(inport_strobe),
        .in_port      (in_port),
        .reg_bank     (reg_bank),
        .bad_dest     (bad_dest),
        .load_count   (load_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rg(input int i);
        return reg_bank[32*i +: 32];
    endfunction

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [4:0] sel, input logic [31:0] data);
        lb.load_valid = 1'b1;
        lb.dest_sel   = sel;
        lb.bus_data   = data;
    endtask

    int          sels[4] = '{1, 2, 3, 5};
    logic [31:0] vals[4] = '{32'd20, 32'd100, 32'd145, 32'd243};

    initial begin
        clr = 1'b0; z_load = 1'b0; pc_inc = 1'b0; inport_strobe = 1'b0;
        alu_result = '0; in_port = '0;
        drive_load(5'd3, 32'h1234);
        step(); step();
        chk("rst_bank_zero", {63'd0, |reg_bank}, 64'd0);
        chk("rst_count", load_count, 0);
        chk("rst_bad", bad_dest, 0);
        chk("rst_ready", lb.load_ready, 0);

        clr = 1'b1; lb.load_valid = 1'b0;
        #1;
        chk("ready_after_rst", lb.load_ready, 1);
        step(); step();
        chk("no_survivor_r3", rg(3), 0);
        chk("no_survivor_cnt", load_count, 0);

        for (int i = 0; i < 4; i++) begin
            drive_load(5'(sels[i]), vals[i]);
            step();
            chk("no_forward", rg(sels[i]), 0);
            if (i > 0) chk("load_visible", rg(sels[i-1]), vals[i-1]);
        end
        lb.load_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) chk("load_final", rg(sels[i]), vals[i]);
        chk("load_count4", load_count, 4);
        chk("r4_untouched", rg(4), 0);

        drive_load(5'd22, 32'hDEAD);
        step();
        drive_load(5'd27, 32'hDEAD);
        step();
        lb.load_valid = 1'b0;
        step();
        chk("inport_ro", rg(22), 0);
        chk("bad_set", bad_dest, 1);
        chk("bad_cnt", load_count, 4);
        chk("bad_r1_kept", rg(1), 20);
        chk("bad_r0", rg(0), 0);
        chk("bad_r23", rg(23), 0);
        in_port = 32'h55; inport_strobe = 1'b1;
        step();
        inport_strobe = 1'b0;
        chk("inport_cap", rg(22), 32'h55);

        drive_load(5'd18, 32'h77);
        step();
        lb.load_valid = 1'b0;
        z_load = 1'b1; alu_result = 64'h00000001_00000002;
        step();
        z_load = 1'b0;
        chk("zhi_bus_wins", rg(18), 32'h77);
        chk("zlo_from_alu", rg(19), 32'h2);
        chk("z_cnt", load_count, 5);
        chk("bad_sticky", bad_dest, 1);

        z_load = 1'b1; alu_result = 64'hAAAABBBB_CCCCDDDD;
        step();
        z_load = 1'b0;
        chk("z_only_hi", rg(18), 32'hAAAABBBB);
        chk("z_only_lo", rg(19), 32'hCCCCDDDD);

        drive_load(5'd20, 32'hFFFFFFFF);
        step();
        lb.load_valid = 1'b0;
        step();
        chk("pc_load", rg(20), 32'hFFFFFFFF);
        pc_inc = 1'b1;
        step();
        pc_inc = 1'b0;
        chk("pc_wrap", rg(20), 0);
        drive_load(5'd20, 32'h40);
        step();
        lb.load_valid = 1'b0;
        pc_inc = 1'b1;
        step();
        pc_inc = 1'b0;
        chk("pc_bus_wins", rg(20), 32'h40);
        chk("pc_cnt", load_count, 7);

        drive_load(5'd4, 32'd9);
        step();
        lb.load_valid = 1'b0;
        clr = 1'b0;
        step();
        clr = 1'b1;
        step();
        chk("midrst_r4", rg(4), 0);
        chk("midrst_cnt", load_count, 0);
        chk("midrst_bad", bad_dest, 0);
        chk("midrst_bank", {63'd0, |reg_bank}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
